cpu_ctrl_seq: RTL and testbench

Parametrised successor of the three-state CPU control unit for the experiment CPU. It decodes IR and sequences FETCH/DECODE/EXEC, with four additions:
- Register-field width is generic.
- Memory accesses wait on a ready handshake.
- HALT is an explicit state, left through a resume input.
- A retired-instruction counter.

It sits between IR/PSW and the datapath (PC, MAR, DR, RAM, register file, AU, I/O).

---
 rtl/cpu_ctrl_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_cpu_ctrl_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: FETCH/DECODE/EXEC/HALT control sequencer for the experiment CPU.
// Decodes IR into datapath strobes, stalls memory accesses on a ready handshake,
// and counts retired instructions. Strobes are combinational from the current
// state, IR and handshake inputs, and are forced low while rst_n is low.
module cpu_ctrl_seq #(
    parameter int RAW    = 2,
    parameter int MEM_HS = 1,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4+2*RAW-1:0]   IR,
    input  logic                 gf,
    input  logic                 mem_rdy,
    input  logic                 resume,
    output logic [2:0]           state,
    output logic                 ld_pc,
    output logic                 in_pc,
    output logic                 ram_re,
    output logic                 ram_we,
    output logic                 ld_mar,
    output logic                 ld_dr,
    output logic                 ld_ir,
    output logic                 reg_we,
    output logic                 s0,
    output logic                 au_en,
    output logic                 g_en,
    output logic                 in_en,
    output logic                 out_en,
    output logic                 sm_en,
    output logic [1:0]           s,
    output logic [RAW-1:0]       SR,
    output logic [RAW-1:0]       DR,
    output logic [3:0]           ac,
    output logic                 halted,
    output logic [CNT_W-1:0]     retired
);

    localparam int IW = 4 + 2*RAW;

    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1010;
    localparam logic [3:0] OP_JG   = 4'b1011;
    localparam logic [3:0] OP_MOVA = 4'b0100;
    localparam logic [3:0] OP_MOVB = 4'b0101;
    localparam logic [3:0] OP_MOVC = 4'b0110;
    localparam logic [3:0] OP_MOVD = 4'b0111;
    localparam logic [3:0] OP_MOVI = 4'b1110;
    localparam logic [3:0] OP_IN   = 4'b1100;
    localparam logic [3:0] OP_OUT  = 4'b1101;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_HALT   = 3'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    logic [3:0]         op_s;
    logic [RAW-1:0]     rd_s, rs_s;
    logic               rdy_s, is_jump_s, mem_op_s, valid_op_s, retire_s;

    logic               ld_pc_s, in_pc_s, ram_re_s, ram_we_s, ld_mar_s, ld_dr_s, ld_ir_s;
    logic               reg_we_s, s0_s, au_en_s, g_en_s, in_en_s, out_en_s, sm_en_s, halted_s;
    logic [1:0]         s_s;
    logic [3:0]         ac_s;
    logic [RAW-1:0]     sr_s, dr_s;

    assign op_s       = IR[IW-1:IW-4];
    assign rd_s       = IR[2*RAW-1:RAW];
    assign rs_s       = IR[RAW-1:0];
    // Without the handshake every access completes in its first cycle.
    assign rdy_s      = (MEM_HS == 0) ? 1'b1 : mem_rdy;
    assign is_jump_s  = (op_s == OP_JMP) || (op_s == OP_JG);
    assign mem_op_s   = (op_s == OP_MOVI) || (op_s == OP_MOVC) || (op_s == OP_MOVB);
    // Opcodes 0000..0011 are the only undefined ones; they execute as NOPs.
    assign valid_op_s = op_s[3] | op_s[2];

    // State register and retired-instruction counter, reset synchronously.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            retired_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Counter next value: one step per completed EXEC, wrapping naturally.
    always_comb begin
        retired_d = retired_q;
        if (retire_s) begin
            retired_d = retired_q + CNT_W'(1'b1);
        end else begin
            retired_d = retired_q;
        end
    end

    // Destination register select, decoded the same way in every state.
    always_comb begin
        dr_s = rd_s;
        case (op_s)
            OP_MOVI: dr_s = {RAW{1'b0}};
            OP_MOVD: dr_s = {RAW{1'b1}};
            default: dr_s = rd_s;
        endcase
    end

    // Next-state and raw strobe decode; commit strobes only on access completion.
    always_comb begin
        state_d  = state_q;
        retire_s = 1'b0;
        ld_pc_s  = 1'b0;
        in_pc_s  = 1'b0;
        ram_re_s = 1'b0;
        ram_we_s = 1'b0;
        ld_mar_s = 1'b0;
        ld_dr_s  = 1'b0;
        ld_ir_s  = 1'b0;
        reg_we_s = 1'b0;
        s0_s     = 1'b0;
        au_en_s  = 1'b0;
        g_en_s   = 1'b0;
        in_en_s  = 1'b0;
        out_en_s = 1'b0;
        sm_en_s  = 1'b1;
        halted_s = 1'b0;
        s_s      = 2'b00;
        ac_s     = 4'b0000;
        sr_s     = rs_s;
        case (state_q)
            ST_FETCH: begin
                ld_mar_s = 1'b1;
                ram_re_s = 1'b1;
                if (rdy_s) begin
                    ld_ir_s = 1'b1;
                    in_pc_s = 1'b1;
                    if (is_jump_s) begin
                        state_d = ST_DECODE;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                ld_dr_s = 1'b1;
                sr_s    = {RAW{1'b1}};
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                ac_s    = 4'b0100;
                ld_dr_s = valid_op_s;
                s0_s    = valid_op_s;
                if (is_jump_s) begin
                    sr_s = {RAW{1'b1}};
                end else begin
                    sr_s = rs_s;
                end
                case (op_s)
                    OP_ADD:  begin au_en_s = 1'b1; ac_s = 4'b1000; reg_we_s = 1'b1; end
                    OP_SUB:  begin au_en_s = 1'b1; ac_s = 4'b1001; g_en_s = 1'b1; reg_we_s = 1'b1; end
                    OP_JMP:  ld_pc_s = 1'b1;
                    OP_JG:   ld_pc_s = gf;
                    OP_MOVA: begin au_en_s = 1'b1; reg_we_s = 1'b1; end
                    OP_MOVB: begin au_en_s = 1'b1; ram_we_s = 1'b1; s_s = 2'b10; end
                    OP_MOVC: begin ram_re_s = 1'b1; s_s = 2'b01; reg_we_s = rdy_s; end
                    OP_MOVD: begin s0_s = 1'b0; reg_we_s = 1'b1; end
                    OP_MOVI: begin ram_re_s = 1'b1; in_pc_s = rdy_s; reg_we_s = rdy_s; end
                    OP_IN:   begin in_en_s = 1'b1; reg_we_s = 1'b1; end
                    OP_OUT:  begin au_en_s = 1'b1; out_en_s = 1'b1; end
                    OP_HALT: ld_pc_s = 1'b0;
                    default: ld_pc_s = 1'b0;
                endcase
                if (mem_op_s && !rdy_s) begin
                    state_d = ST_EXEC;
                end else if (op_s == OP_HALT) begin
                    state_d  = ST_HALT;
                    retire_s = 1'b1;
                end else begin
                    state_d  = ST_FETCH;
                    retire_s = 1'b1;
                end
            end
            ST_HALT: begin
                sm_en_s  = 1'b0;
                halted_s = 1'b1;
                if (resume) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Output stage: while rst_n is low every strobe is held at zero.
    always_comb begin
        state   = state_q;
        retired = retired_q;
        SR      = sr_s;
        DR      = dr_s;
        if (!rst_n) begin
            ld_pc  = 1'b0; in_pc  = 1'b0; ram_re = 1'b0; ram_we = 1'b0;
            ld_mar = 1'b0; ld_dr  = 1'b0; ld_ir  = 1'b0; reg_we = 1'b0;
            s0     = 1'b0; au_en  = 1'b0; g_en   = 1'b0; in_en  = 1'b0;
            out_en = 1'b0; sm_en  = 1'b0; halted = 1'b0;
            s      = 2'b00;
            ac     = 4'b0000;
        end else begin
            ld_pc  = ld_pc_s;  in_pc  = in_pc_s;  ram_re = ram_re_s; ram_we = ram_we_s;
            ld_mar = ld_mar_s; ld_dr  = ld_dr_s;  ld_ir  = ld_ir_s;  reg_we = reg_we_s;
            s0     = s0_s;     au_en  = au_en_s;  g_en   = g_en_s;   in_en  = in_en_s;
            out_en = out_en_s; sm_en  = sm_en_s;  halted = halted_s;
            s      = s_s;
            ac     = ac_s;
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Self-checking bench for cpu_ctrl_seq: directed scenarios with literal
// expectations, then randomized stimulus against an instruction-level model.
module tb_cpu_ctrl_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- DUT A: default parameters ----------------
    logic        rst_n, gf, mem_rdy, resume;
    logic [7:0]  ir;
    logic [2:0]  a_state;
    logic a_ld_pc, a_in_pc, a_ram_re, a_ram_we, a_ld_mar, a_ld_dr, a_ld_ir, a_reg_we;
    logic a_s0, a_au_en, a_g_en, a_in_en, a_out_en, a_sm_en, a_halted;
    logic [1:0]  a_s, a_SR, a_DR;
    logic [3:0]  a_ac;
    logic [15:0] a_retired;
    logic [14:0] a_strb;
    assign a_strb = {a_ld_pc, a_in_pc, a_ram_re, a_ram_we, a_ld_mar, a_ld_dr, a_ld_ir, a_reg_we,
                     a_s0, a_au_en, a_g_en, a_in_en, a_out_en, a_sm_en, a_halted};

    cpu_ctrl_seq dut_a (
        .clk(clk), .rst_n(rst_n), .IR(ir), .gf(gf), .mem_rdy(mem_rdy), .resume(resume),
        .state(a_state), .ld_pc(a_ld_pc), .in_pc(a_in_pc), .ram_re(a_ram_re), .ram_we(a_ram_we),
        .ld_mar(a_ld_mar), .ld_dr(a_ld_dr), .ld_ir(a_ld_ir), .reg_we(a_reg_we), .s0(a_s0),
        .au_en(a_au_en), .g_en(a_g_en), .in_en(a_in_en), .out_en(a_out_en), .sm_en(a_sm_en),
        .s(a_s), .SR(a_SR), .DR(a_DR), .ac(a_ac), .halted(a_halted), .retired(a_retired)
    );

    // ---------------- DUT B: RAW=3, no handshake, 2-bit counter ----------------
    logic        b_rst_n, b_gf, b_rdy, b_resume;
    logic [9:0]  b_ir;
    logic [2:0]  b_state;
    logic b_ld_pc, b_in_pc, b_ram_re, b_ram_we, b_ld_mar, b_ld_dr, b_ld_ir, b_reg_we;
    logic b_s0, b_au_en, b_g_en, b_in_en, b_out_en, b_sm_en, b_halted;
    logic [1:0]  b_s;
    logic [2:0]  b_SR, b_DR;
    logic [3:0]  b_ac;
    logic [1:0]  b_retired;
    logic [14:0] b_strb;
    assign b_strb = {b_ld_pc, b_in_pc, b_ram_re, b_ram_we, b_ld_mar, b_ld_dr, b_ld_ir, b_reg_we,
                     b_s0, b_au_en, b_g_en, b_in_en, b_out_en, b_sm_en, b_halted};

    cpu_ctrl_seq #(.RAW(3), .MEM_HS(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .IR(b_ir), .gf(b_gf), .mem_rdy(b_rdy), .resume(b_resume),
        .state(b_state), .ld_pc(b_ld_pc), .in_pc(b_in_pc), .ram_re(b_ram_re), .ram_we(b_ram_we),
        .ld_mar(b_ld_mar), .ld_dr(b_ld_dr), .ld_ir(b_ld_ir), .reg_we(b_reg_we), .s0(b_s0),
        .au_en(b_au_en), .g_en(b_g_en), .in_en(b_in_en), .out_en(b_out_en), .sm_en(b_sm_en),
        .s(b_s), .SR(b_SR), .DR(b_DR), .ac(b_ac), .halted(b_halted), .retired(b_retired)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // ---------------- Instruction-level reference model (DUT A) ----------------
    // Phase within the current instruction: 0 fetch, 1 decode, 2 execute, 3 halted.
    int          m_st     = 0;
    int unsigned m_ret    = 0;
    bit          model_on = 1'b0;

    function automatic bit is_jump(input logic [3:0] op);
        return (op == 4'b1010) || (op == 4'b1011);
    endfunction

    function automatic bit is_mem(input logic [3:0] op);
        return (op == 4'b1110) || (op == 4'b0110) || (op == 4'b0101);
    endfunction

    // Expected outputs for a given phase, instruction and handshake inputs.
    function automatic void model_out(input int st, input logic [7:0] ins, input logic g,
                                      input logic r, input logic rn,
                                      output logic [14:0] strb, output logic [1:0] es,
                                      output logic [1:0] esr, output logic [1:0] edr,
                                      output logic [3:0] eac);
        logic [3:0] op;
        logic [1:0] rd, rs;
        bit pc_l, pc_i, re, we, mar, ldd, ldi, rw, sel0, au, ge, ie, oe, sm, hl;
        bit movi, movc, movb, movd, nop;
        op = ins[7:4]; rd = ins[3:2]; rs = ins[1:0];
        movi = (op == 4'b1110); movc = (op == 4'b0110);
        movb = (op == 4'b0101); movd = (op == 4'b0111);
        nop  = (op < 4'd4);
        {pc_l, pc_i, re, we, mar, ldd, ldi, rw, sel0, au, ge, ie, oe, sm, hl} = 15'd0;
        es  = 2'd0;
        eac = 4'd0;
        esr = rs;
        edr = movi ? 2'd0 : (movd ? 2'd3 : rd);
        if (st == 0) begin
            mar = 1; re = 1; ldi = r; pc_i = r; sm = 1;
        end else if (st == 1) begin
            ldd = 1; sm = 1; esr = 2'd3;
        end else if (st == 2) begin
            sm  = 1;
            esr = is_jump(op) ? 2'd3 : rs;
            es  = movc ? 2'd1 : (movb ? 2'd2 : 2'd0);
            eac = (op == 4'b1000) ? 4'd8 : ((op == 4'b1001) ? 4'd9 : 4'd4);
            if (!nop) begin
                ldd  = 1;
                sel0 = !movd;
                pc_i = movi && r;
                pc_l = (op == 4'b1010) || ((op == 4'b1011) && g);
                re   = movi || movc;
                we   = movb;
                rw   = !(is_jump(op) || op == 4'b1111 || movb || op == 4'b1101) && (!(movi || movc) || r);
                au   = (op == 4'b1000) || (op == 4'b1001) || (op == 4'b0100) || movb || (op == 4'b1101);
                ge   = (op == 4'b1001);
                ie   = (op == 4'b1100);
                oe   = (op == 4'b1101);
            end
        end else begin
            hl = 1;
        end
        strb = rn ? {pc_l, pc_i, re, we, mar, ldd, ldi, rw, sel0, au, ge, ie, oe, sm, hl} : 15'd0;
    endfunction

    // Model advance at each rising edge from the inputs present at that edge.
    initial begin
        logic [3:0] op;
        forever begin
            @(posedge clk);
            op = ir[7:4];
            if (!rst_n) begin
                m_st = 0; m_ret = 0; model_on = 1'b1;
            end else if (model_on) begin
                case (m_st)
                    0: if (mem_rdy) m_st = is_jump(op) ? 1 : 2;
                    1: m_st = 2;
                    2: if (!(is_mem(op) && !mem_rdy)) begin
                           m_ret = (m_ret + 1) % 65536;
                           m_st  = (op == 4'b1111) ? 3 : 0;
                       end
                    3: if (resume) m_st = 0;
                    default: m_st = 0;
                endcase
            end
        end
    end

    // Per-cycle comparison of DUT A against the model, away from the rising edge.
    initial begin
        logic [14:0] e_strb;
        logic [1:0]  e_s, e_sr, e_dr;
        logic [3:0]  e_ac;
        forever begin
            @(negedge clk);
            if (model_on) begin
                model_out(m_st, ir, gf, mem_rdy, rst_n, e_strb, e_s, e_sr, e_dr, e_ac);
                chk("m_state",   32'(a_state),   32'(m_st));
                chk("m_strobes", 32'(a_strb),    32'(e_strb));
                chk("m_retired", 32'(a_retired), 32'(m_ret));
                if (rst_n) begin
                    chk("m_dr", 32'(a_DR), 32'(e_dr));
                    if (m_st == 0 || m_st == 2) chk("m_s",  32'(a_s),  32'(e_s));
                    if (m_st == 1 || m_st == 2) chk("m_sr", 32'(a_SR), 32'(e_sr));
                    if (m_st == 2)              chk("m_ac", 32'(a_ac), 32'(e_ac));
                end
            end
        end
    end

    // ---------------- Stimulus ----------------
    initial begin
        logic [2:0] rd3, rs3;
        rst_n = 1'b0; ir = 8'h00; gf = 1'b0; mem_rdy = 1'b0; resume = 1'b0;
        b_rst_n = 1'b0; b_ir = 10'd0; b_gf = 1'b0; b_rdy = 1'b0; b_resume = 1'b0;

        // Reset state.
        tick(); tick();
        settle();
        chk("rst_state",   32'(a_state),   32'd0);
        chk("rst_strobes", 32'(a_strb),    32'd0);
        chk("rst_retired", 32'(a_retired), 32'd0);

        // 1: ADD R1,R2.
        tick(); rst_n = 1'b1; ir = 8'h86; mem_rdy = 1'b1;
        settle();
        chk("t1_f_state", 32'(a_state), 32'd0);
        chk("t1_f_ld_ir", 32'(a_ld_ir), 32'd1);
        chk("t1_f_in_pc", 32'(a_in_pc), 32'd1);
        tick(); settle();
        chk("t1_e_state",  32'(a_state),  32'd2);
        chk("t1_e_au_en",  32'(a_au_en),  32'd1);
        chk("t1_e_ac",     32'(a_ac),     32'h8);
        chk("t1_e_reg_we", 32'(a_reg_we), 32'd1);
        chk("t1_e_dr",     32'(a_DR),     32'd1);
        chk("t1_e_sr",     32'(a_SR),     32'd2);
        tick(); ir = 8'hB0; gf = 1'b1;
        settle();
        chk("t1_retired", 32'(a_retired), 32'd1);

        // 2: JG taken, then not taken.
        for (int k = 0; k < 2; k++) begin
            tick(); settle();
            chk("t2_d_state", 32'(a_state), 32'd1);
            chk("t2_d_sr",    32'(a_SR),    32'd3);
            tick(); settle();
            chk("t2_e_state", 32'(a_state), 32'd2);
            chk("t2_e_sr",    32'(a_SR),    32'd3);
            chk("t2_e_ld_pc", 32'(a_ld_pc), (k == 0) ? 32'd1 : 32'd0);
            tick();
            if (k == 0) gf = 1'b0; else ir = 8'h69;
            settle();
            chk("t2_f_state", 32'(a_state), 32'd0);
        end

        // 3: MOVC with three stalled EXEC cycles.
        tick(); mem_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            settle();
            chk("t3_stall_state",  32'(a_state),  32'd2);
            chk("t3_stall_ram_re", 32'(a_ram_re), 32'd1);
            chk("t3_stall_s",      32'(a_s),      32'd1);
            chk("t3_stall_reg_we", 32'(a_reg_we), 32'd0);
        end
        tick(); mem_rdy = 1'b1;
        settle();
        chk("t3_done_reg_we", 32'(a_reg_we),  32'd1);
        chk("t3_done_ret",    32'(a_retired), 32'd3);
        tick(); ir = 8'hF0;
        settle();
        chk("t3_retired", 32'(a_retired), 32'd4);

        // 4: HALT, ten idle cycles, then resume.
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("t4_state",   32'(a_state),   32'd3);
            chk("t4_strobes", 32'(a_strb),    32'd1);
            chk("t4_retired", 32'(a_retired), 32'd5);
            tick();
        end
        resume = 1'b1;
        settle();
        chk("t4_resume_hold", 32'(a_state), 32'd3);
        tick(); resume = 1'b0; ir = 8'h54;
        settle();
        chk("t4_resume_state", 32'(a_state), 32'd0);

        // 5: reset during a stalled MOVB.
        tick(); mem_rdy = 1'b0;
        settle();
        chk("t5_ram_we", 32'(a_ram_we), 32'd1);
        chk("t5_s",      32'(a_s),      32'd2);
        tick(); rst_n = 1'b0;
        settle();
        chk("t5_rst_ram_we", 32'(a_ram_we), 32'd0);
        tick(); settle();
        chk("t5_state",   32'(a_state),   32'd0);
        chk("t5_retired", 32'(a_retired), 32'd0);

        // 6: RAW=3, no handshake, 2-bit counter wrap on DUT B.
        tick(); b_rst_n = 1'b1; b_rdy = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            rd3 = 3'(k + 2); rs3 = 3'(7 - k);
            b_ir = {4'b0100, rd3, rs3};
            settle();
            chk("t6_f_state",   32'(b_state),   32'd0);
            chk("t6_f_strobes", 32'(b_strb),    32'h3502);
            chk("t6_f_retired", 32'(b_retired), 32'((k - 1) % 4));
            tick(); settle();
            chk("t6_e_state",   32'(b_state), 32'd2);
            chk("t6_e_strobes", 32'(b_strb),  32'h02E2);
            chk("t6_e_sr",      32'(b_SR),    32'(rs3));
            chk("t6_e_dr",      32'(b_DR),    32'(rd3));
            chk("t6_e_s_ac",    32'({b_s, b_ac}), 32'h04);
            tick();
        end
        settle();
        chk("t6_wrap", 32'(b_retired), 32'd1);

        // Randomized traffic on DUT A, checked by the model every cycle.
        tick(); rst_n = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst_n   = ($urandom_range(0, 99) != 0);
            mem_rdy = ($urandom_range(0, 2) != 0);
            gf      = 1'($urandom);
            resume  = ($urandom_range(0, 3) == 0);
            if (m_st == 0) ir = 8'($urandom);
        end
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
